priority_shift_reg: RTL and testbench

- Parametrised successor to the single-bit priority D flip-flop: a WIDTH-bit register with the same fixed priority ladder (clear > preset > parallel load > data capture).
- Adds a burst shift/rotate engine: a `start` pulse launches exactly BURST single-bit shifts, with serial out, busy and done.
- Used as a generic loadable/presettable data register and as a parallel-to-serial stage in the lab designs.

---
 rtl/priority_shift_reg_if.sv | 29 ++
 rtl/priority_shift_reg.sv | 95 +++++++++
 tb/tb_priority_shift_reg.sv | 130 +++++++++++++
 3 files changed

// File: rtl/priority_shift_reg_if.sv
// Control, data and status bundle for priority_shift_reg.
// The master drives the controls; the slave (the register) returns q and the burst status.
interface priority_shift_reg_if #(
  parameter int WIDTH = 8
);
  logic             pre;
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic             en;
  logic [WIDTH-1:0] din;
  logic             start;
  logic             dir;
  logic             rot;
  logic             ser_in;
  logic [WIDTH-1:0] q;
  logic             ser_out;
  logic             busy;
  logic             done;

  modport master (
    output pre, load, load_data, en, din, start, dir, rot, ser_in,
    input  q, ser_out, busy, done
  );

  modport slave (
    input  pre, load, load_data, en, din, start, dir, rot, ser_in,
    output q, ser_out, busy, done
  );
endinterface

// File: rtl/priority_shift_reg.sv
// WIDTH-bit register with a fixed priority ladder: clear > preset > load > burst/capture.
// A start pulse launches a burst of exactly BURST one-bit shifts or rotates, with serial out.
module priority_shift_reg #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}},
  parameter int               BURST      = 8
) (
  input  logic                 clk,
  input  logic                 clr,
  priority_shift_reg_if.slave  bus
);

  localparam int             CW   = $clog2(BURST + 1);
  localparam logic [CW-1:0]  LAST = CW'(BURST - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             ser_out_q, ser_out_d;
  logic             done_q, done_d;
  logic [CW-1:0]    count_q, count_d;
  logic             dir_q, dir_d;
  logic             rot_q, rot_d;

  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    ser_out_d = ser_out_q;
    done_d    = 1'b0;
    count_d   = count_q;
    dir_d     = dir_q;
    rot_d     = rot_q;

    if (!bus.pre) begin
      q_d     = PRESET_VAL;
      state_d = IDLE;
      count_d = '0;
    end else if (!bus.load) begin
      q_d     = bus.load_data;
      state_d = IDLE;
      count_d = '0;
    end else if (state_q == SHIFT) begin
      // The leaving bit feeds ser_out and, in rotate mode, re-enters at the far end
      if (!dir_q) begin
        ser_out_d = q_q[0];
        q_d       = {(rot_q ? q_q[0] : bus.ser_in), q_q[WIDTH-1:1]};
      end else begin
        ser_out_d = q_q[WIDTH-1];
        q_d       = {q_q[WIDTH-2:0], (rot_q ? q_q[WIDTH-1] : bus.ser_in)};
      end
      count_d = count_q + 1'b1;
      if (count_q == LAST) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if (bus.start) begin
      state_d = SHIFT;
      count_d = '0;
      dir_d   = bus.dir;
      rot_d   = bus.rot;
    end else if (bus.en) begin
      q_d = bus.din;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q   <= IDLE;
      q_q       <= '0;
      ser_out_q <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
      dir_q     <= 1'b0;
      rot_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      ser_out_q <= ser_out_d;
      done_q    <= done_d;
      count_q   <= count_d;
      dir_q     <= dir_d;
      rot_q     <= rot_d;
    end
  end

  assign bus.q       = q_q;
  assign bus.ser_out = ser_out_q;
  assign bus.busy    = (state_q == SHIFT);
  assign bus.done    = done_q;

endmodule

// File: tb/tb_priority_shift_reg.sv
// Directed bench for priority_shift_reg at WIDTH=8, BURST=3; expected values are hand-derived.
module tb_priority_shift_reg;

  logic clk;
  logic clr;
  int   checks = 0;
  int   passed = 0;

  priority_shift_reg_if #(.WIDTH(8)) bus ();

  priority_shift_reg #(
    .WIDTH      (8),
    .PRESET_VAL (8'hFF),
    .BURST      (3)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input logic [7:0] eq, input logic eser,
                         input logic ebusy, input logic edone);
    chk({tag, ".q"}, bus.q, eq);
    chk({tag, ".ser_out"}, {7'd0, bus.ser_out}, {7'd0, eser});
    chk({tag, ".busy"}, {7'd0, bus.busy}, {7'd0, ebusy});
    chk({tag, ".done"}, {7'd0, bus.done}, {7'd0, edone});
  endtask

  initial begin
    clr = 1'b1;
    bus.pre = 1'b1; bus.load = 1'b1; bus.load_data = 8'h00;
    bus.en = 1'b0; bus.din = 8'h00; bus.start = 1'b0;
    bus.dir = 1'b0; bus.rot = 1'b0; bus.ser_in = 1'b0;
    #1;

    // Clear beats every other control
    clr = 1'b0; bus.pre = 1'b0; bus.load = 1'b0; bus.start = 1'b1; bus.en = 1'b1;
    tick();
    chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);

    // Preset beats load, then load alone
    clr = 1'b1; bus.start = 1'b0; bus.en = 1'b0; bus.load_data = 8'h3C;
    tick();
    chk_all("preset", 8'hFF, 1'b0, 1'b0, 1'b0);
    bus.pre = 1'b1; bus.load_data = 8'hA5;
    tick();
    chk("load", bus.q, 8'hA5);
    bus.load = 1'b1;

    // Right shift with ser_in=1 fill from A5
    bus.dir = 1'b0; bus.rot = 1'b0; bus.ser_in = 1'b1; bus.start = 1'b1;
    tick();
    chk_all("rsh_k", 8'hA5, 1'b0, 1'b1, 1'b0);
    bus.start = 1'b0;
    tick(); chk_all("rsh_1", 8'hD2, 1'b1, 1'b1, 1'b0);
    tick(); chk_all("rsh_2", 8'hE9, 1'b0, 1'b1, 1'b0);
    tick(); chk_all("rsh_3", 8'hF4, 1'b1, 1'b0, 1'b1);
    tick(); chk_all("rsh_after", 8'hF4, 1'b1, 1'b0, 1'b0);

    // Left rotate from 81
    bus.load = 1'b0; bus.load_data = 8'h81;
    tick(); chk("rot_load", bus.q, 8'h81);
    bus.load = 1'b1; bus.dir = 1'b1; bus.rot = 1'b1; bus.start = 1'b1;
    tick(); chk_all("rot_k", 8'h81, 1'b1, 1'b1, 1'b0);
    bus.start = 1'b0;
    tick(); chk_all("rot_1", 8'h03, 1'b1, 1'b1, 1'b0);
    tick(); chk_all("rot_2", 8'h06, 1'b0, 1'b1, 1'b0);
    tick(); chk_all("rot_3", 8'h0C, 1'b0, 1'b0, 1'b1);
    tick(); chk_all("rot_after", 8'h0C, 1'b0, 1'b0, 1'b0);

    // Load aborts a burst at k+2; ser_out keeps the k+1 bit
    bus.load = 1'b0; bus.load_data = 8'hA5;
    tick(); bus.load = 1'b1;
    bus.dir = 1'b0; bus.rot = 1'b0; bus.ser_in = 1'b1; bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    tick(); chk_all("abl_1", 8'hD2, 1'b1, 1'b1, 1'b0);
    bus.load = 1'b0; bus.load_data = 8'h3C;
    tick(); chk_all("abl_2", 8'h3C, 1'b1, 1'b0, 1'b0);
    bus.load = 1'b1;
    tick(); chk_all("abl_3", 8'h3C, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("abl_4", 8'h3C, 1'b1, 1'b0, 1'b0);

    // Clear aborts a burst at k+2
    bus.load = 1'b0; bus.load_data = 8'hA5;
    tick(); bus.load = 1'b1;
    bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    tick(); chk_all("abc_1", 8'hD2, 1'b1, 1'b1, 1'b0);
    clr = 1'b0;
    tick(); chk_all("abc_2", 8'h00, 1'b0, 1'b0, 1'b0);
    clr = 1'b1;
    tick(); chk_all("abc_3", 8'h00, 1'b0, 1'b0, 1'b0);

    // Idle capture
    bus.en = 1'b1; bus.din = 8'h5A;
    tick(); chk("capture", bus.q, 8'h5A);

    // en and start held through a burst; start re-launches in the done cycle
    bus.ser_in = 1'b0; bus.start = 1'b1; bus.din = 8'hFF;
    tick(); chk_all("bb_k", 8'h5A, 1'b0, 1'b1, 1'b0);
    tick(); chk_all("bb_1", 8'h2D, 1'b0, 1'b1, 1'b0);
    tick(); chk_all("bb_2", 8'h16, 1'b1, 1'b1, 1'b0);
    tick(); chk_all("bb_3", 8'h0B, 1'b0, 1'b0, 1'b1);
    tick(); chk_all("bb2_k", 8'h0B, 1'b0, 1'b1, 1'b0);
    bus.start = 1'b0; bus.en = 1'b0;
    tick(); chk_all("bb2_1", 8'h05, 1'b1, 1'b1, 1'b0);
    tick(); chk_all("bb2_2", 8'h02, 1'b1, 1'b1, 1'b0);
    tick(); chk_all("bb2_3", 8'h01, 1'b0, 1'b0, 1'b1);
    tick(); chk_all("bb2_after", 8'h01, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
